mem_arbiter: RTL and testbench

Two-port arbiter that shares the single-ported 4096x16 unified memory of the multi-cycle CPU between two requesters: port 0 (instruction fetch) and port 1 (data load/store).
- Each access is a req/ack handshake.
- Round-robin arbitration on simultaneous requests.
- Drives the memory's address, write-data, read-enable and write-enable signals.
- Returns registered read data with a one-cycle ack pulse.

---
 rtl/mem_arbiter.sv | 107 ++++++++++
 tb/tb_mem_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port req/ack arbiter sharing one single-ported memory (IDLE -> ACCESS -> DONE).
// Define MEM_ARB_PRIORITY_EN for fixed priority to port 0; round-robin otherwise.
module mem_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              busy,
  output logic              grant_id
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t              state, state_nxt;
  logic                grant_valid;
  logic                winner;
  logic                last_grant;
  logic                we_l;
  logic [ADDR_W-1:0]   addr_l;
  logic [DATA_W-1:0]   wdata_l;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // NOTE: every output of this block is given a default first, so no path can infer a latch.
  always_comb begin
    state_nxt   = state;
    grant_valid = 1'b0;
    winner      = 1'b0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          grant_valid = 1'b1;
          state_nxt   = ACCESS;
          if (req0 && req1) begin
`ifdef MEM_ARB_PRIORITY_EN
            winner = 1'b0;
`else
            winner = ~last_grant;
`endif
          end else begin
            winner = req1;
          end
        end
      end
      ACCESS:  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Winner's request is frozen here so requester changes after the grant are ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_l       <= 1'b0;
      addr_l     <= '0;
      wdata_l    <= '0;
      grant_id   <= 1'b0;
      last_grant <= 1'b1;
      rdata0     <= '0;
      rdata1     <= '0;
    end else begin
      if (grant_valid) begin
        we_l       <= winner ? we1    : we0;
        addr_l     <= winner ? addr1  : addr0;
        wdata_l    <= winner ? wdata1 : wdata0;
        grant_id   <= winner;
        last_grant <= winner;
      end
      if (state == ACCESS) begin
        if (grant_id) rdata1 <= we_l ? '0 : mem_read_data;
        else          rdata0 <= we_l ? '0 : mem_read_data;
      end
    end
  end

  // Memory strobes decode from the state register only; reset kills a write instantly.
  assign mem_address    = addr_l;
  assign mem_write_data = wdata_l;
  assign mem_read       = (state == ACCESS) && !we_l;
  assign mem_write      = (state == ACCESS) &&  we_l;
  assign ack0           = (state == DONE) && !grant_id;
  assign ack1           = (state == DONE) &&  grant_id;
  assign busy           = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized rounds
// checked against a transaction-level model (ordered grants, reference memory).
module tb_mem_arbiter;

`ifdef MEM_ARB_PRIORITY_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, we0, req1, we1;
  logic [11:0] addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        ack0, ack1;
  logic [15:0] rdata0, rdata1;
  logic [11:0] mem_address;
  logic [15:0] mem_write_data, mem_read_data;
  logic        mem_read, mem_write, busy, grant_id;

  logic [15:0] mem [4096];
  logic        pl_en;
  logic [11:0] pl_addr;
  logic [15:0] pl_data;

  logic [15:0] ref_mem [4096];
  logic [15:0] exp_rdata [2];
  bit          lg;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read(mem_read), .mem_write(mem_write), .mem_read_data(mem_read_data),
    .busy(busy), .grant_id(grant_id)
  );

  assign mem_read_data = mem[mem_address];
  always @(posedge clk) begin
    if (mem_write)  mem[mem_address] <= mem_write_data;
    else if (pl_en) mem[pl_addr]     <= pl_data;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timed out");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [11:0] a, input logic [15:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    ref_mem[a] = d;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic drive(input bit p, input bit r, input bit w, input logic [11:0] a, input logic [15:0] d);
    if (p) begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
    else   begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    lg = 1'b1;
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
  endtask

  // One isolated access with cycle-exact checks on strobes, ack timing and read data.
  task automatic single(input bit p, input bit w, input logic [11:0] a, input logic [15:0] d);
    logic [15:0] e;
    e = w ? 16'h0000 : ref_mem[a];
    if (w) ref_mem[a] = d;
    drive(p, 1'b1, w, a, d);
    tick();
    check("acc_busy", busy, 1);
    check("acc_mem_read", mem_read, !w);
    check("acc_mem_write", mem_write, w);
    check("acc_addr", mem_address, a);
    check("acc_no_ack", {ack1, ack0}, 0);
    if (w) check("acc_wdata", mem_write_data, d);
    tick();
    check("done_ack", {ack1, ack0}, p ? 2'b10 : 2'b01);
    check("done_rdata", p ? rdata1 : rdata0, e);
    check("done_other_rdata", p ? rdata0 : rdata1, exp_rdata[!p]);
    check("done_grant_id", grant_id, p);
    check("done_strobes", {mem_read, mem_write}, 0);
    drive(p, 1'b0, w, a, d);
    tick();
    check("idle_ack", {ack1, ack0}, 0);
    check("idle_busy", busy, 0);
    exp_rdata[p] = e;
    lg = p;
  endtask

  // Random round: chosen ports request together; model predicts grant order and results.
  task automatic round(input bit r0, input bit r1);
    bit          w [2];
    logic [11:0] a [2];
    logic [15:0] d [2];
    bit          order [2];
    int          n, idx;
    bit          p;
    logic [15:0] e;
    for (int i = 0; i < 2; i++) begin
      w[i] = 1'($urandom_range(0, 1));
      a[i] = 12'($urandom_range(0, 15));
      d[i] = 16'($urandom);
    end
    n = int'(r0) + int'(r1);
    if (r0 && r1) order[0] = PRIO ? 1'b0 : ~lg;
    else          order[0] = r1;
    order[1] = ~order[0];
    if (r0) drive(1'b0, 1'b1, w[0], a[0], d[0]);
    if (r1) drive(1'b1, 1'b1, w[1], a[1], d[1]);
    idx = 0;
    for (int c = 0; c < 12 && idx < n; c++) begin
      tick();
      if (ack0 || ack1) begin
        p = ack1;
        check("rnd_single_ack", {ack1, ack0} != 2'b11, 1);
        check("rnd_order", p, order[idx]);
        e = w[p] ? 16'h0000 : ref_mem[a[p]];
        if (w[p]) ref_mem[a[p]] = d[p];
        check("rnd_rdata", p ? rdata1 : rdata0, e);
        check("rnd_other_rdata", p ? rdata0 : rdata1, exp_rdata[!p]);
        check("rnd_grant_id", grant_id, p);
        exp_rdata[p] = e;
        lg = p;
        drive(p, 1'b0, w[p], a[p], d[p]);
        idx++;
      end
    end
    check("rnd_completed", idx, n);
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
    check("rnd_idle", busy, 0);
  endtask

  initial begin
    rst = 1'b0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
    lg = 1'b1;
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
    #12;
    check("rst_ack", {ack1, ack0}, 0);
    check("rst_rdata0", rdata0, 0);
    check("rst_rdata1", rdata1, 0);
    check("rst_strobes", {mem_read, mem_write}, 0);
    check("rst_mem_address", mem_address, 0);
    check("rst_mem_wdata", mem_write_data, 0);
    check("rst_busy", busy, 0);
    check("rst_grant_id", grant_id, 0);
    tick();
    rst = 1'b1;

    for (int i = 0; i < 16; i++) preload(12'(i), 16'($urandom));
    preload(12'd200, 16'h00AB);
    preload(12'd204, 16'h5555);
    preload(12'd300, 16'hBEEF);
    preload(12'd301, 16'hDEAD);

    single(1'b0, 1'b0, 12'd200, 16'h0000);
    single(1'b1, 1'b1, 12'd204, 16'h1234);
    single(1'b0, 1'b0, 12'd204, 16'h0000);
    check("wr_rd_204", rdata0, 16'h1234);

    drive(1'b0, 1'b1, 1'b0, 12'd300, 16'h0000);
    tick();
    drive(1'b0, 1'b1, 1'b0, 12'd301, 16'h0000);
    check("latched_addr", mem_address, 12'd300);
    tick();
    check("latched_ack", ack0, 1);
    check("latched_rdata", rdata0, 16'hBEEF);
    drive(1'b0, 1'b0, 1'b0, 12'd301, 16'h0000);
    tick();
    exp_rdata[0] = 16'hBEEF;
    lg = 1'b0;

    do_reset();
    drive(1'b0, 1'b1, 1'b0, 12'd10, 16'h0000);
    drive(1'b1, 1'b1, 1'b0, 12'd11, 16'h0000);
    for (int i = 0; i < 12; i++) begin
      bit ep;
      tick();
      ep = PRIO ? 1'b0 : 1'((i / 3) % 2);
      if (i % 3 == 1) begin
        check("tie_ack", {ack1, ack0}, ep ? 2'b10 : 2'b01);
        check("tie_grant_id", grant_id, ep);
      end else begin
        check("tie_no_ack", {ack1, ack0}, 0);
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    tick();

    do_reset();
    preload(12'd5, 16'h0001);
    drive(1'b1, 1'b1, 1'b1, 12'd5, 16'hFFFF);
    tick();
    check("abort_write_active", mem_write, 1);
    #2 rst = 1'b0;
    #1;
    check("abort_write_drop", mem_write, 0);
    check("abort_busy", busy, 0);
    check("abort_ack", ack1, 0);
    check("abort_rdata0", rdata0, 0);
    drive(1'b1, 1'b0, 1'b1, 12'd5, 16'hFFFF);
    tick();
    rst = 1'b1;
    lg = 1'b1;
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
    check("abort_mem5", mem[5], 16'h0001);
    tick();
    check("abort_no_ack", {ack1, ack0}, 0);
    check("abort_idle", busy, 0);

    for (int r = 0; r < 40; r++) begin
      int k;
      k = int'($urandom_range(0, 3));
      if (k == 0) round(1'b1, 1'b0);
      else if (k == 1) round(1'b0, 1'b1);
      else round(1'b1, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
